rr_merge2: RTL and testbench
============================

RR_MERGE2 -- requirements
Module: rr_merge2

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 1, giving the data width of every data port.
REQ-002 The block SHALL have i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have i_a, input, BUS_WIDTH, channel A data.
REQ-005 The block SHALL have i_a_valid, input, 1, channel A data valid.
REQ-006 The block SHALL have o_a_ready, output, 1, channel A accepted this cycle when high with i_a_valid.
REQ-007 The block SHALL have i_b, input, BUS_WIDTH, channel B data.
REQ-008 The block SHALL have i_b_valid, input, 1, channel B data valid.
REQ-009 The block SHALL have o_b_ready, output, 1, channel B accepted this cycle when high with i_b_valid.
REQ-010 The block SHALL have o_c, output, BUS_WIDTH, merged data (registered).
REQ-011 The block SHALL have o_c_valid, output, 1, o_c holds a word.
REQ-012 The block SHALL have i_c_ready, input, 1, downstream consumes o_c this cycle when high with o_c_valid.
REQ-013 The block SHALL have o_s, output, 1, source of held word: 0 = A, 1 = B (polarity matches selector i_s: 1 selects i_b).

Function
REQ-014 Transfer on a channel SHALL occur exactly on a rising edge where its valid and ready are both high.
REQ-015 Output register SHALL be one entry; accept condition "open" = !o_c_valid || i_c_ready (same-cycle drain and refill allowed).
REQ-016 Grant: only A valid -> A; only B valid -> B; both valid -> channel not recorded in last-served pointer; neither -> none.
REQ-017 o_a_ready SHALL be open && grant==A; o_b_ready SHALL be open && grant==B; never both high in one cycle.
REQ-018 Ready SHALL depend combinationally only on i_a_valid, i_b_valid, i_c_ready and state; o_c_valid, o_c, o_s SHALL be register outputs only.
REQ-019 On an accepted transfer: o_c <= granted data, o_s <= granted source, o_c_valid <= 1, last-served pointer <= granted source; latency input-accept to o_c_valid = 1 cycle.
REQ-020 When open and no grant: o_c_valid <= 0 if it was drained; o_c and o_s SHALL hold their last values.
REQ-021 When !open (o_c_valid=1, i_c_ready=0): o_c, o_s, o_c_valid, pointer SHALL hold; both readies low.
REQ-022 Last-served pointer SHALL update only on an accepted transfer, not on grants blocked by backpressure.
REQ-023 Under continuous dual valid and i_c_ready=1, grants SHALL strictly alternate A,B,A,B,... giving full throughput (one word per cycle).
REQ-024 Valid deassertion without transfer upstream SHALL NOT affect state; no data loss or duplication under any valid/ready pattern.
REQ-025 Data values SHALL pass unmodified; no width conversion.

Reset
REQ-026 While i_rst_n=0: o_c_valid=0, o_c=0, o_s=0, last-served pointer=B (so A wins first tie), o_a_ready=o_b_ready=0.
REQ-027 Reset assertion mid-operation SHALL immediately (asynchronously) discard the held word; first edge after deassertion behaves as from empty.

Verification
REQ-028 Reset then A valid only, i_a=0x1 (BUS_WIDTH=8), i_c_ready=1 -> o_a_ready=1 same cycle; next cycle o_c=0x01, o_c_valid=1, o_s=0.
REQ-029 Both valid continuously, A=0xAA, B=0xBB, i_c_ready=1 -> o_c sequence 0xAA,0xBB,0xAA,0xBB; o_s 0,1,0,1; no bubbles.
REQ-030 Word held, i_c_ready=0 for 3 cycles with both valid -> o_c, o_s stable, both readies 0; on i_c_ready=1 next grant follows pointer (alternates from held source).
REQ-031 Only B valid for 3 words then both valid -> B,B,B then A granted first on tie.
REQ-032 Assert i_rst_n=0 between edges while o_c_valid=1 -> o_c_valid, o_c, o_s go 0 without a clock edge; after release both valid -> A granted first.
REQ-033 Random valid/ready stress, 10k cycles -> scoreboard: per-channel order preserved, every accepted word output exactly once with correct o_s, no ready high with !open.

Source files
------------

// File: rtl/rr_merge2.sv
// Two-input round-robin merge into a single registered output slot.
// Ties alternate via a last-served pointer; the slot may drain and refill in the same cycle.
module rr_merge2 #(
  parameter int BUS_WIDTH = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [BUS_WIDTH-1:0] i_a,
  input  logic                 i_a_valid,
  output logic                 o_a_ready,
  input  logic [BUS_WIDTH-1:0] i_b,
  input  logic                 i_b_valid,
  output logic                 o_b_ready,
  output logic [BUS_WIDTH-1:0] o_c,
  output logic                 o_c_valid,
  input  logic                 i_c_ready,
  output logic                 o_s
);

  logic                 vld_p0;
  logic [BUS_WIDTH-1:0] c_data_p0;
  logic                 c_src_p0;
  logic                 last_src;
  logic                 open;
  logic                 grant_a;
  logic                 grant_b;
  logic                 accept;

  // On a tie the channel that was not served last wins; last_src = 1 means B.
  always_comb begin
    open    = !vld_p0 || i_c_ready;
    grant_b = i_b_valid && (!i_a_valid || !last_src);
    grant_a = i_a_valid && !grant_b;
    accept  = open && (grant_a || grant_b);
  end

  // Readies are forced low while reset is held so nothing is offered during reset.
  assign o_a_ready = i_rst_n && open && grant_a;
  assign o_b_ready = i_rst_n && open && grant_b;

  // Output slot (stage p0)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0    <= 1'b0;
      c_data_p0 <= '0;
      c_src_p0  <= 1'b0;
      last_src  <= 1'b1;
    end else if (open) begin
      if (accept) begin
        vld_p0    <= 1'b1;
        c_data_p0 <= grant_b ? i_b : i_a;
        c_src_p0  <= grant_b;
        last_src  <= grant_b;
      end else begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign o_c       = c_data_p0;
  assign o_c_valid = vld_p0;
  assign o_s       = c_src_p0;

endmodule

// File: tb/tb_rr_merge2.sv
// Randomized and directed checks of rr_merge2 against a transaction-level reference model.
module tb_rr_merge2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         av, bv, cr;
  logic         a_rdy, b_rdy;
  logic [W-1:0] c;
  logic         c_vld;
  logic         s;

  int checks = 0;
  int errors = 0;

  // Reference model: held word, its source, and which channel was served last.
  int           m_vld;
  int           m_src;
  int           m_last;
  logic [W-1:0] m_data;
  int           exp_q[$];

  rr_merge2 #(.BUS_WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a(a), .i_a_valid(av), .o_a_ready(a_rdy),
    .i_b(b), .i_b_valid(bv), .o_b_ready(b_rdy),
    .o_c(c), .o_c_valid(c_vld), .i_c_ready(cr), .o_s(s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (av && bv) return 1 - m_last;
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_vld  = 0;
    m_src  = 0;
    m_last = 1;
    m_data = '0;
    exp_q.delete();
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    int  g;
    int  open;
    int  ent;
    #1;
    open = (m_vld == 0) || cr;
    g    = model_grant();
    chk("a_ready", a_rdy, (open && g == 0) ? 1 : 0);
    chk("b_ready", b_rdy, (open && g == 1) ? 1 : 0);
    chk("c_valid_pre", c_vld, m_vld);
    if (c_vld && cr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        ent = exp_q.pop_front();
        chk("sb_data", c, ent & 8'hFF);
        chk("sb_src", s, ent >> 8);
      end
    end
    @(posedge clk);
    if (open) begin
      if (g >= 0) begin
        m_vld  = 1;
        m_src  = g;
        m_last = g;
        m_data = (g == 1) ? b : a;
        exp_q.push_back((g << 8) | m_data);
      end else begin
        m_vld = 0;
      end
    end
    #1;
    chk("c_valid", c_vld, m_vld);
    chk("c_data", c, m_data);
    chk("c_src", s, m_src);
    @(negedge clk);
  endtask

  task automatic drive(input logic iav, input logic [W-1:0] ia, input logic ibv,
                       input logic [W-1:0] ib, input logic icr);
    av = iav; a = ia; bv = ibv; b = ib; cr = icr;
    cycle();
  endtask

  // Asserts reset between edges and checks the asynchronous clear; returns at a falling edge.
  task automatic do_reset();
    av = 1'b1; bv = 1'b1; cr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_c_valid", c_vld, 0);
    chk("rst_c", c, 0);
    chk("rst_s", s, 0);
    chk("rst_a_ready", a_rdy, 0);
    chk("rst_b_ready", b_rdy, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] seq029 [4];
    seq029[0] = 8'hAA; seq029[1] = 8'hBB; seq029[2] = 8'hAA; seq029[3] = 8'hBB;
    rst_n = 1'b0; av = 0; bv = 0; a = '0; b = '0; cr = 0;
    model_reset();
    @(negedge clk);
    chk("init_c_valid", c_vld, 0);
    chk("init_a_ready", a_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single A word after reset
    av = 1; a = 8'h01; bv = 0; b = '0; cr = 1;
    #1 chk("r028_a_ready", a_rdy, 1);
    #0;
    @(negedge clk);
    chk("r028_c", c, 8'h01);
    chk("r028_vld", c_vld, 1);
    chk("r028_s", s, 0);
    m_vld = 1; m_src = 0; m_last = 0; m_data = 8'h01; exp_q.push_back(8'h01);
    drive(0, 0, 0, 0, 1);

    // Continuous ties alternate starting with A
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hAA, 1, 8'hBB, 1);
      chk("r029_c", c, seq029[i]);
      chk("r029_s", s, i % 2);
      chk("r029_vld", c_vld, 1);
    end

    // Backpressure holds everything; pointer continues from held source
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hAA, 1, 8'hBB, 0);
      chk("r030_c", c, 8'hBB);
      chk("r030_s", s, 1);
    end
    drive(1, 8'hAA, 1, 8'hBB, 1);
    chk("r030_next_s", s, 0);
    chk("r030_next_c", c, 8'hAA);

    // B alone three times, then A wins the tie
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 8'h00, 1, 8'h10 + W'(i), 1);
      chk("r031_s", s, 1);
      chk("r031_c", c, 8'h10 + W'(i));
    end
    drive(1, 8'h55, 1, 8'h66, 1);
    chk("r031_tie_s", s, 0);

    // Async reset while a word is held
    chk("r032_pre_vld", c_vld, 1);
    do_reset();
    drive(1, 8'h77, 1, 8'h88, 1);
    chk("r032_first_s", s, 0);
    chk("r032_first_c", c, 8'h77);

    // Random stress
    for (int i = 0; i < 10000; i++) begin
      drive(W'($urandom_range(0, 1)), W'($urandom), W'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end
    chk("final_queue", exp_q.size(), m_vld);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
